// File: rtl/ila_pkg.sv
// Shared types and helpers for the ILA capture controller.
// Holds the capture FSM states, default depth and the chronological address helper.
package ila_pkg;

    localparam int ADDR_W = 9;
    localparam int N      = 2**ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } state_t;

    // Physical address of logical sample idx when the oldest sample
    // lives at start; wraps modulo 2**aw.
    function automatic int unsigned chrono_addr(
        input int unsigned start,
        input int unsigned idx,
        input int unsigned aw
    );
        return (start + idx) & ((32'd1 << aw) - 32'd1);
    endfunction

endpackage

// File: rtl/ila_readout.sv
// Two-stage readout pipeline for the sample RAM port B.
// Ports: clk/rst, req/start/idx in, RAM port B enables/address, RAM data in, rd_data/rd_valid out.
module ila_readout
    import ila_pkg::*;
#(
    parameter int P_DATA_WIDTH = 20,
    parameter int P_ADDR_WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic [P_ADDR_WIDTH-1:0] start,
    input  logic [P_ADDR_WIDTH-1:0] idx,
    input  logic [P_DATA_WIDTH-1:0] b_dout,
    output logic                    b_men,
    output logic                    b_ren,
    output logic [P_ADDR_WIDTH-1:0] b_addr,
    output logic [P_DATA_WIDTH-1:0] rd_data,
    output logic                    rd_valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            b_men    <= 1'b0;
            b_ren    <= 1'b0;
            b_addr   <= '0;
            rd_valid <= 1'b0;
        end else begin
            b_men    <= req;
            b_ren    <= req;
            rd_valid <= b_ren;
            if (req) begin
                b_addr <= P_ADDR_WIDTH'(chrono_addr(
                    32'(start), 32'(idx), P_ADDR_WIDTH));
            end
        end
    end

    // The RAM output register is the second pipeline stage, so the
    // data is forwarded in the same cycle the valid flag rises.
    assign rd_data = rd_valid ? b_dout : '0;

endmodule

// File: rtl/ila_capture_ctrl.sv
// Capture controller: circular pre/post-trigger write into port A, ordered readout on port B.
// Ports: CLK/RST, ARM/PRETRIG, SAMPLE_EN/SAMPLE_IN/TRIG_IN, status, RD_* readout, A_* and B_* RAM ports.
module ila_capture_ctrl
    import ila_pkg::*;
#(
    parameter int P_DATA_WIDTH = 20,
    parameter int P_ADDR_WIDTH = 9
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ARM,
    input  logic [P_ADDR_WIDTH-1:0] PRETRIG,
    input  logic                    SAMPLE_EN,
    input  logic [P_DATA_WIDTH-1:0] SAMPLE_IN,
    input  logic                    TRIG_IN,
    output logic                    BUSY,
    output logic                    TRIGGERED,
    output logic                    DONE,
    output logic [P_ADDR_WIDTH-1:0] TRIG_ADDR,
    input  logic                    RD_REQ,
    input  logic [P_ADDR_WIDTH-1:0] RD_IDX,
    output logic [P_DATA_WIDTH-1:0] RD_DATA,
    output logic                    RD_VALID,
    output logic                    A_MEN,
    output logic                    A_WEN,
    output logic [P_ADDR_WIDTH-1:0] A_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BM,
    output logic                    B_MEN,
    output logic                    B_REN,
    output logic [P_ADDR_WIDTH-1:0] B_ADDR,
    input  logic [P_DATA_WIDTH-1:0] B_DOUT
);

    localparam logic [P_ADDR_WIDTH-1:0] A_ONE = P_ADDR_WIDTH'(1);

    state_t                  state;
    state_t                  state_nxt;
    logic [P_ADDR_WIDTH-1:0] pre_r;
    logic [P_ADDR_WIDTH-1:0] wptr;
    logic [P_ADDR_WIDTH-1:0] cnt;
    logic [P_ADDR_WIDTH-1:0] post_cnt;
    logic [P_ADDR_WIDTH-1:0] pre_nxt;
    logic [P_ADDR_WIDTH-1:0] wptr_nxt;
    logic [P_ADDR_WIDTH-1:0] cnt_nxt;
    logic [P_ADDR_WIDTH-1:0] post_nxt;
    logic [P_ADDR_WIDTH-1:0] trig_nxt;
    logic                    trg_nxt;
    logic                    wr;
    logic                    rd_go;

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pre_nxt   = pre_r;
        wptr_nxt  = wptr;
        cnt_nxt   = cnt;
        post_nxt  = post_cnt;
        trig_nxt  = TRIG_ADDR;
        trg_nxt   = TRIGGERED;
        wr        = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (ARM) begin
                    pre_nxt   = PRETRIG;
                    wptr_nxt  = '0;
                    cnt_nxt   = '0;
                    post_nxt  = '0;
                    trg_nxt   = 1'b0;
                    state_nxt = (PRETRIG == '0) ? ST_ARMED : ST_PRE;
                end
            end
            ST_PRE: begin
                if (SAMPLE_EN) begin
                    wr       = 1'b1;
                    wptr_nxt = wptr + A_ONE;
                    cnt_nxt  = cnt + A_ONE;
                    if (cnt_nxt == pre_r) state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (SAMPLE_EN) begin
                    wr       = 1'b1;
                    wptr_nxt = wptr + A_ONE;
                    if (TRIG_IN) begin
                        trig_nxt  = wptr;
                        trg_nxt   = 1'b1;
                        // N-1-pre_r is the bitwise complement of pre_r.
                        post_nxt  = ~pre_r;
                        state_nxt = (~pre_r == '0) ? ST_DONE : ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (SAMPLE_EN) begin
                    wr       = 1'b1;
                    wptr_nxt = wptr + A_ONE;
                    post_nxt = post_cnt - A_ONE;
                    if (post_cnt == A_ONE) state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_r     <= '0;
            wptr      <= '0;
            cnt       <= '0;
            post_cnt  <= '0;
            TRIG_ADDR <= '0;
            TRIGGERED <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            A_MEN     <= 1'b0;
            A_WEN     <= 1'b0;
            A_ADDR    <= '0;
            A_DIN     <= '0;
        end else begin
            pre_r     <= pre_nxt;
            wptr      <= wptr_nxt;
            cnt       <= cnt_nxt;
            post_cnt  <= post_nxt;
            TRIG_ADDR <= trig_nxt;
            TRIGGERED <= trg_nxt;
            BUSY      <= (state_nxt == ST_PRE) ||
                         (state_nxt == ST_ARMED) ||
                         (state_nxt == ST_POST);
            DONE      <= (state_nxt == ST_DONE);
            A_MEN     <= wr;
            A_WEN     <= wr;
            if (wr) begin
                A_ADDR <= wptr;
                A_DIN  <= SAMPLE_IN;
            end
        end
    end

    assign A_BM  = '1;
    assign rd_go = RD_REQ && (state == ST_DONE);

    ila_readout #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_ADDR_WIDTH (P_ADDR_WIDTH)
    ) u_readout (
        .clk      (CLK),
        .rst      (RST),
        .req      (rd_go),
        .start    (TRIG_ADDR - pre_r),
        .idx      (RD_IDX),
        .b_dout   (B_DOUT),
        .b_men    (B_MEN),
        .b_ren    (B_REN),
        .b_addr   (B_ADDR),
        .rd_data  (RD_DATA),
        .rd_valid (RD_VALID)
    );

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Directed bench for ila_capture_ctrl with N=16 and a behavioural two-port RAM.
// Ports: none; drives the DUT and prints one summary line.
module tb_ila_capture_ctrl;

    localparam int DW = 20;
    localparam int AW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ARM;
    logic [AW-1:0] PRETRIG;
    logic          SAMPLE_EN;
    logic [DW-1:0] SAMPLE_IN;
    logic          TRIG_IN;
    logic          BUSY;
    logic          TRIGGERED;
    logic          DONE;
    logic [AW-1:0] TRIG_ADDR;
    logic          RD_REQ;
    logic [AW-1:0] RD_IDX;
    logic [DW-1:0] RD_DATA;
    logic          RD_VALID;
    logic          A_MEN;
    logic          A_WEN;
    logic [AW-1:0] A_ADDR;
    logic [DW-1:0] A_DIN;
    logic [DW-1:0] A_BM;
    logic          B_MEN;
    logic          B_REN;
    logic [AW-1:0] B_ADDR;
    logic [DW-1:0] B_DOUT;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    logic [DW-1:0] mem [16];

    ila_capture_ctrl #(
        .P_DATA_WIDTH (DW),
        .P_ADDR_WIDTH (AW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ARM       (ARM),
        .PRETRIG   (PRETRIG),
        .SAMPLE_EN (SAMPLE_EN),
        .SAMPLE_IN (SAMPLE_IN),
        .TRIG_IN   (TRIG_IN),
        .BUSY      (BUSY),
        .TRIGGERED (TRIGGERED),
        .DONE      (DONE),
        .TRIG_ADDR (TRIG_ADDR),
        .RD_REQ    (RD_REQ),
        .RD_IDX    (RD_IDX),
        .RD_DATA   (RD_DATA),
        .RD_VALID  (RD_VALID),
        .A_MEN     (A_MEN),
        .A_WEN     (A_WEN),
        .A_ADDR    (A_ADDR),
        .A_DIN     (A_DIN),
        .A_BM      (A_BM),
        .B_MEN     (B_MEN),
        .B_REN     (B_REN),
        .B_ADDR    (B_ADDR),
        .B_DOUT    (B_DOUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (A_MEN && A_WEN) mem[A_ADDR] <= A_DIN;
        if (B_MEN && B_REN) B_DOUT <= mem[B_ADDR];
    end

    always @(negedge CLK) begin
        if (mon_en) begin
            total++;
            assert (!(A_MEN && B_MEN)) else begin
                bad++;
                $error("FAIL port_overlap observed=%0b%0b expected=not both",
                       A_MEN, B_MEN);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic arm(input logic [AW-1:0] p);
        ARM       = 1'b1;
        PRETRIG   = p;
        SAMPLE_EN = 1'b0;
        TRIG_IN   = 1'b0;
        step();
        ARM = 1'b0;
    endtask

    task automatic samp(input int k, input logic t, input logic en);
        SAMPLE_IN = DW'(k);
        TRIG_IN   = t;
        SAMPLE_EN = en;
        step();
        SAMPLE_EN = 1'b0;
        TRIG_IN   = 1'b0;
    endtask

    task automatic read1(input logic [AW-1:0] idx, input int exp,
                         input string tag);
        RD_REQ = 1'b1;
        RD_IDX = idx;
        step();
        RD_REQ = 1'b0;
        chk({tag, "_lat1"}, RD_VALID, 0);
        chk({tag, "_bmen"}, B_MEN, 1);
        step();
        chk({tag, "_vld"}, RD_VALID, 1);
        chk({tag, "_data"}, RD_DATA, exp);
    endtask

    initial begin
        RST = 1'b1; ARM = 1'b0; PRETRIG = '0; SAMPLE_EN = 1'b0;
        SAMPLE_IN = '0; TRIG_IN = 1'b0; RD_REQ = 1'b0; RD_IDX = '0;
        step();
        step();
        chk("rst_busy", BUSY, 0);
        chk("rst_trig", TRIGGERED, 0);
        chk("rst_done", DONE, 0);
        chk("rst_rdv", RD_VALID, 0);
        chk("rst_amen", A_MEN, 0);
        chk("rst_bmen", B_MEN, 0);
        chk("rst_aaddr", A_ADDR, 0);
        chk("rst_baddr", B_ADDR, 0);
        chk("rst_taddr", TRIG_ADDR, 0);
        chk("a_bm", A_BM, 20'hFFFFF);
        RST = 1'b0;
        mon_en = 1'b1;
        step();

        // Capture 1: PRETRIG=4, trigger on sample 20
        arm(4);
        chk("t1_busy", BUSY, 1);
        for (int k = 0; k < 32; k++) begin
            samp(k, k == 20, 1'b1);
            if (k == 20) begin
                chk("t1_trig", TRIGGERED, 1);
                chk("t1_taddr", TRIG_ADDR, 4);
            end
            if (k == 30) chk("t1_done_early", DONE, 0);
        end
        chk("t1_done", DONE, 1);
        chk("t1_busy_end", BUSY, 0);
        chk("t1_last_aaddr", A_ADDR, 15);
        chk("t1_last_adin", A_DIN, 31);
        step();
        read1(0, 16, "t1_rd0");
        chk("t1_baddr0", B_ADDR, 0);
        for (int c = 0; c < 18; c++) begin
            RD_REQ = (c < 16);
            RD_IDX = AW'(c);
            step();
            if (c >= 1 && c <= 16) begin
                chk("t1_b2b_vld", RD_VALID, 1);
                chk("t1_b2b_data", RD_DATA, 16 + c - 1);
            end
        end
        chk("t1_b2b_end", RD_VALID, 0);

        // Capture 2: PRETRIG=0, trigger on first sample
        arm(0);
        chk("t2_trig_clr", TRIGGERED, 0);
        chk("t2_done_clr", DONE, 0);
        for (int k = 0; k < 16; k++) begin
            samp(k, k == 0, 1'b1);
            if (k == 0) begin
                chk("t2_trig", TRIGGERED, 1);
                chk("t2_taddr", TRIG_ADDR, 0);
            end
            if (k == 14) chk("t2_done_early", DONE, 0);
        end
        chk("t2_done", DONE, 1);
        step();
        read1(0, 0, "t2_rd0");
        read1(15, 15, "t2_rd15");

        // Capture 3: PRETRIG=15, no post samples
        arm(15);
        for (int k = 0; k < 21; k++) begin
            samp(k, k == 20, 1'b1);
            if (k == 19) begin
                chk("t3_done_early", DONE, 0);
                chk("t3_trig_early", TRIGGERED, 0);
            end
        end
        chk("t3_done", DONE, 1);
        chk("t3_taddr", TRIG_ADDR, 4);
        chk("t3_trig", TRIGGERED, 1);
        step();
        read1(15, 20, "t3_rd15");
        read1(0, 5, "t3_rd0");

        // Capture 4: trigger ignored in PRE and on unqualified cycles
        arm(4);
        for (int k = 0; k < 4; k++) begin
            samp(k, 1'b1, 1'b1);
            chk("t4_pre_trig", TRIGGERED, 0);
        end
        samp(99, 1'b1, 1'b0);
        chk("t4_noen_trig", TRIGGERED, 0);
        chk("t4_noen_amen", A_MEN, 0);
        samp(4, 1'b0, 1'b1);
        samp(5, 1'b0, 1'b1);
        samp(6, 1'b1, 1'b1);
        chk("t4_trig", TRIGGERED, 1);
        chk("t4_taddr", TRIG_ADDR, 6);
        chk("t4_busy", BUSY, 1);
        ARM = 1'b1; PRETRIG = '0; RD_REQ = 1'b1;
        SAMPLE_EN = 1'b1; SAMPLE_IN = 7;
        step();
        ARM = 1'b0; RD_REQ = 1'b0;
        chk("t4_arm_busy_trig", TRIGGERED, 1);
        chk("t4_arm_busy_taddr", TRIG_ADDR, 6);
        chk("t4_rdreq_busy_bmen", B_MEN, 0);
        samp(8, 1'b0, 1'b1);
        chk("t4_rdreq_busy_vld", RD_VALID, 0);
        chk("t4_arm_busy_aaddr", A_ADDR, 8);
        chk("t4_busy2", BUSY, 1);

        RST = 1'b1; SAMPLE_EN = 1'b1; SAMPLE_IN = 9; TRIG_IN = 1'b1;
        step();
        RST = 1'b0;
        chk("t5_busy", BUSY, 0);
        chk("t5_trig", TRIGGERED, 0);
        chk("t5_done", DONE, 0);
        chk("t5_rdv", RD_VALID, 0);
        chk("t5_amen", A_MEN, 0);
        chk("t5_awen", A_WEN, 0);
        chk("t5_bmen", B_MEN, 0);
        chk("t5_bren", B_REN, 0);
        chk("t5_aaddr", A_ADDR, 0);
        chk("t5_baddr", B_ADDR, 0);
        chk("t5_taddr", TRIG_ADDR, 0);
        RD_REQ = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t5_idle_amen", A_MEN, 0);
            chk("t5_idle_bmen", B_MEN, 0);
            chk("t5_idle_rdv", RD_VALID, 0);
        end
        RD_REQ = 1'b0; SAMPLE_EN = 1'b0; TRIG_IN = 1'b0;
        step();
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ila_capture_ctrl.md
Name: ila_capture_ctrl

Overview:
Capture controller for the integrated logic analyser. It sits directly upstream of the two-port sample RAM. Port A of the RAM is its circular write port, filled with probe samples around a trigger event. Port B is its readout port, which returns captured samples in chronological order (oldest first) to the host/JTAG side. Reads and writes never overlap in time, so RAM port-collision handling is never exercised.

Parameters:
P_DATA_WIDTH, 20, probe sample width; equals RAM data width
P_ADDR_WIDTH, 9, RAM address width; capture depth N = 2**P_ADDR_WIDTH

Ports:
CLK  in  1  single system clock; drives both RAM port clocks
RST  in  1  synchronous, active-high reset
ARM  in  1  one-cycle pulse; starts a capture
PRETRIG  in  P_ADDR_WIDTH  number of samples kept before the trigger; latched on ARM
SAMPLE_EN  in  1  sample qualifier; only qualified cycles are written or counted
SAMPLE_IN  in  P_DATA_WIDTH  probe data
TRIG_IN  in  1  trigger condition; evaluated only when SAMPLE_EN=1
BUSY  out  1  capture in progress (PRE, ARMED or POST)
TRIGGERED  out  1  trigger has been accepted for the current capture
DONE  out  1  capture complete; readout allowed
TRIG_ADDR  out  P_ADDR_WIDTH  physical RAM address of the trigger sample
RD_REQ  in  1  readout request; honoured only in DONE
RD_IDX  in  P_ADDR_WIDTH  logical sample index; 0 = oldest
RD_DATA  out  P_DATA_WIDTH  sample returned by readout
RD_VALID  out  1  RD_DATA valid (one-cycle pulse)
A_MEN, A_WEN  out  1  RAM port A enables (A_REN tied 0)
A_ADDR  out  P_ADDR_WIDTH  RAM port A address
A_DIN, A_BM  out  P_DATA_WIDTH  RAM port A write data and bit mask (A_BM all ones)
B_MEN, B_REN  out  1  RAM port B enables (B_WEN tied 0, B_BM 0)
B_ADDR  out  P_ADDR_WIDTH  RAM port B address
B_DOUT  in  P_DATA_WIDTH  RAM port B read data

Behaviour:
- Reset: the FSM goes to IDLE.
  - BUSY, TRIGGERED, DONE, RD_VALID, A_MEN, A_WEN, B_MEN and B_REN are 0.
  - A_ADDR, B_ADDR, TRIG_ADDR, write pointer and counters are 0.
  - RST mid-capture or mid-readout aborts immediately. No further RAM access occurs.
- All outputs are registered. A_DIN is SAMPLE_IN registered together with A_MEN/A_WEN/A_ADDR, so the RAM writes a sample 1 cycle after it is presented.
- FSM states: IDLE, PRE, ARMED, POST, DONE.
  - IDLE/DONE, on ARM: latch PRETRIG into pre_r, clear wptr, cnt, TRIGGERED and DONE.
    - pre_r = 0: go to ARMED.
    - otherwise: go to PRE.
  - PRE: each qualified cycle writes at wptr, then wptr++ (wraps modulo N) and cnt++. When cnt reaches pre_r, go to ARMED. TRIG_IN is ignored in PRE.
  - ARMED: each qualified cycle writes at wptr, then wptr++ (circular).
    - TRIG_IN=1 on a qualified cycle: that sample is written; TRIG_ADDR = wptr; TRIGGERED=1; post_cnt = N-1-pre_r; go to POST.
    - If post_cnt = 0, go straight to DONE instead.
  - POST: each qualified cycle writes one sample and decrements post_cnt. The write of the final sample (post_cnt 1 to 0) moves the FSM to DONE, and DONE is asserted in the cycle after that write issues.
  - DONE: no writes. ARM restarts a capture (PRE or ARMED, per the rule above).
- ARM while BUSY is ignored. SAMPLE_EN=0 cycles hold all counters and issue no RAM access.
- Total samples per capture = N: exactly pre_r before the trigger, the trigger sample, and N-1-pre_r after it.
- Readout:
  - RD_REQ in DONE (cycle t): in t+1, B_MEN = B_REN = 1 and B_ADDR = (TRIG_ADDR - pre_r + RD_IDX) mod N.
  - The RAM registers the data at the next edge. At t+2 (two-cycle latency), RD_DATA = B_DOUT and RD_VALID = 1.
  - Back-to-back RD_REQ is allowed, giving one result per cycle.
  - RD_REQ outside DONE is ignored: no RD_VALID.
- Address arithmetic is unsigned, width P_ADDR_WIDTH, with natural wrap.
- Port A and port B are never active in the same cycle.

Decomposition:
- Package ila_pkg holds:
  - the state enum (IDLE, PRE, ARMED, POST, DONE)
  - localparam N = 2**P_ADDR_WIDTH
  - a function for the chronological address: start + idx mod N
- One natural sub-module, ila_readout: the 2-stage read pipeline (request register, RAM access, RD_VALID generation).
- The FSM and write-pointer logic stay in the top module.

Test Plan:
- Bench uses P_ADDR_WIDTH=4 (N=16) and SAMPLE_IN = running counter 0,1,2,…, with TRIG_IN at sample 20.
- PRETRIG=4, SAMPLE_EN=1, ARM -> TRIG_ADDR=4; DONE after sample 31; reading RD_IDX 0..15 returns 16..31 in order, each RD_VALID 2 cycles after RD_REQ.
- PRETRIG=0, trigger on first sample (value 0) -> TRIG_ADDR=0, 15 post samples written; RD_IDX 0 returns 0; DONE after 16 writes.
- PRETRIG=15 -> post_cnt=0, DONE the cycle after the trigger write; RD_IDX 15 returns 20 and RD_IDX 0 returns 5.
- TRIG_IN high during PRE and on SAMPLE_EN=0 cycles -> ignored; TRIGGERED stays 0 until the first qualified ARMED trigger.
- RST asserted in POST -> all outputs 0 next cycle, no A_MEN afterwards. ARM while BUSY, and RD_REQ while BUSY -> no effect, RD_VALID stays 0.
- Throughout all tests: assert that A_MEN and B_MEN are never both 1 in the same cycle.
